calculate_unit: RTL and testbench
=================================

// Module: calculate_unit
// PURPOSE
// - Signed 32-bit arithmetic engine of the keypad calculator. Sits between the interface block and the display path.
// - Applies one of five operators to two operands that interface supplies.
// - Registers the result on ans, which feeds back to interface and on to segment_driver.
// - Replaces any out-of-range, illegal or divide-by-zero result with the display ERROR code.
// PARAMETERS
// - MAX_POS   999999        largest result the 6-digit display shows
// - MIN_NEG   -99999        most negative result: sign digit plus 5 digits
// - ERR_CODE  32'h00EE_0000 sentinel word that segment_driver renders as "Error"
// PORTS
// - sw_clk    in   1   system clock. One clock only; everything is on its rising edge.
// - rst       in   1   reset, synchronous, active-high
// - operand1  in   32  left operand, signed two's complement
// - operand2  in   32  right operand, signed two's complement
// - operator  in   3   0=none, 1=*, 2=/, 3=+, 4=-, 5=%, 6/7=illegal
// - ans       out  32  registered signed result, or ERR_CODE
// BEHAVIOUR
// - Reset: when rst=1 at a rising sw_clk edge, ans <= 0. Reset overrides any operation.
// - Latency: 1 cycle. Inputs are sampled at a rising edge and ans updates at that same edge.
//   - ans is recomputed on every edge; there is no start/done handshake.
//   - ans holds steady while the inputs are steady.
// - Arithmetic: both operands are sign-extended to 64 bits, then the operation runs in 64 bits.
//   - *  full 64-bit signed product.
//   - /  signed quotient, truncated toward zero (e.g. 100000 / -500 = -200).
//   - %  signed remainder; sign follows operand1 (e.g. -10 % 101 = -10; -10 % -101 = -10).
//   - +, -  64-bit, so they cannot wrap.
// - Error conditions (ans <= ERR_CODE):
//   - operand2 = 0 with operator 2 or 5.
//   - operand1 or operand2 outside [MIN_NEG, MAX_POS]. Because ERR_CODE is itself out of range, an error propagates through chained operations.
//   - 64-bit result outside [MIN_NEG, MAX_POS].
//   - operator 6 or 7.
// - operator 0: ans <= operand1, subject to the same operand range check.
// - Boundaries:
//   - Result exactly 999999 or -99999 is valid. 1000000 and -100000 give ERR_CODE.
//   - Result 0 is emitted as 32'h0, never as a negative zero.
// - An operand or operator change takes effect at the next edge, with no hazard beyond that cycle.
// STRUCTURE
// - Shared package calc_pkg holds:
//   - operator localparams OP_NONE=0, OP_MUL=1, OP_DIV=2, OP_ADD=3, OP_SUB=4, OP_MOD=5;
//   - ERR_CODE, MAX_POS, MIN_NEG;
//   - the other display sentinels, 32'h00CC_0000 (blank) and 32'h00B0_0000 (ANS).
// - interface and segment_driver import the same package.
// - One natural sub-module is calc_range_check: a combinational 64-bit in-range compare, instantiated 3 times (operand1, operand2, result).
// - The datapath is combinational, followed by a single 32-bit output register.
// TESTING
// - Drive rst=1 for 2 cycles -> ans=0. Release rst -> ans follows the inputs 1 cycle later.
// - 10 op 101, operator 3/4/1/2/5 -> ans = 111, -91, 1010, 0, 10.
// - -10 op 101 -> 91, -111, -1010, 0, -10.
//   - -10 op -101 -> -111, 91, 1010, 0, -10.
// - 100000 op -500, operator 3/4/1/2/5 -> 99500, 100500, ERR_CODE (product -50000000), -200, 0.
// - 1023 op 0, operator 3/4/1/2/5 -> 1023, 1023, 0, ERR_CODE, ERR_CODE.
//   - Operator 6 or 7 -> ERR_CODE.
// - Range edges:
//   - 999998 + 1 -> 999999.
//   - 999999 + 1 -> ERR_CODE.
//   - -99999 - 1 -> ERR_CODE.
//   - operand1 = ERR_CODE, operator 3 -> ERR_CODE.
//   - Assert rst in the middle of a sequence -> ans=0 at the next edge.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants for the keypad calculator.
// Holds the operator encodings, the displayable result range and the
// sentinel words that the display path renders as special glyphs.
// Imported by calculate_unit, calc_range_check, interface and segment_driver.
package calc_pkg;

    // Operator encodings supplied by the interface block.
    // Codes 6 and 7 are illegal.
    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_MUL  = 3'd1;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_ADD  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_MOD  = 3'd5;

    // Displayable range. Six digits when positive; a sign digit plus
    // five digits when negative.
    localparam logic signed [63:0] MAX_POS = 64'sd999999;
    localparam logic signed [63:0] MIN_NEG = -64'sd99999;

    // Display sentinels. ERR_CODE lies outside the valid range, so an
    // error that is fed back as an operand produces another error.
    localparam logic [31:0] ERR_CODE   = 32'h00EE_0000;
    localparam logic [31:0] BLANK_CODE = 32'h00CC_0000;
    localparam logic [31:0] ANS_CODE   = 32'h00B0_0000;

endpackage

// File: rtl/calc_range_check.sv
// Combinational range compare for the calculator datapath.
// Ports:
//   value    in  64  signed value to test
//   in_range out 1   high when MIN_NEG <= value <= MAX_POS
module calc_range_check
    import calc_pkg::*;
(
    input  logic signed [63:0] value,
    output logic               in_range
);

    always_comb begin
        in_range = (value >= MIN_NEG) && (value <= MAX_POS);
    end

endmodule

// File: rtl/calculate_unit.sv
// Signed arithmetic engine of the keypad calculator.
// Applies the selected operator to two 32-bit signed operands in 64-bit
// arithmetic and registers the result, or ERR_CODE when the operands or
// result are out of the displayable range, the divisor is zero, or the
// operator is illegal. One cycle latency; recomputed on every edge.
// Ports:
//   sw_clk   in  1   system clock, rising edge
//   rst      in  1   synchronous active-high reset, clears ans to 0
//   operand1 in  32  left operand, signed two's complement
//   operand2 in  32  right operand, signed two's complement
//   operator in  3   0=none 1=* 2=/ 3=+ 4=- 5=% 6/7=illegal
//   ans      out 32  registered signed result or ERR_CODE
module calculate_unit
    import calc_pkg::*;
(
    input  logic        sw_clk,
    input  logic        rst,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  logic [2:0]  operator,
    output logic [31:0] ans
);

    logic signed [63:0] a_ext;
    logic signed [63:0] b_ext;
    logic signed [63:0] b_safe;
    logic signed [63:0] result;
    logic               op_legal;
    logic               div_by_zero;
    logic               a_ok;
    logic               b_ok;
    logic               r_ok;
    logic [31:0]        ans_d;
    logic [31:0]        ans_q;

    always_comb begin
        a_ext = {{32{operand1[31]}}, operand1};
        b_ext = {{32{operand2[31]}}, operand2};
        // Substitute a harmless divisor so the divider never sees zero;
        // the zero case is flagged separately and overrides the result.
        b_safe = (operand2 == 32'd0) ? 64'sd1 : b_ext;
    end

    always_comb begin
        result      = 64'sd0;
        op_legal    = 1'b1;
        div_by_zero = 1'b0;
        case (operator)
            OP_NONE: result = a_ext;
            OP_MUL:  result = a_ext * b_ext;
            OP_DIV: begin
                result      = a_ext / b_safe;
                div_by_zero = (operand2 == 32'd0);
            end
            OP_ADD:  result = a_ext + b_ext;
            OP_SUB:  result = a_ext - b_ext;
            OP_MOD: begin
                // SystemVerilog % truncates, so the sign follows operand1.
                result      = a_ext % b_safe;
                div_by_zero = (operand2 == 32'd0);
            end
            default: op_legal = 1'b0;
        endcase
    end

    calc_range_check u_check_a (
        .value    (a_ext),
        .in_range (a_ok)
    );

    calc_range_check u_check_b (
        .value    (b_ext),
        .in_range (b_ok)
    );

    calc_range_check u_check_r (
        .value    (result),
        .in_range (r_ok)
    );

    always_comb begin
        // operand2 is checked even for OP_NONE so that an error fed back
        // on either side always propagates.
        if (!op_legal || div_by_zero || !a_ok || !b_ok || !r_ok) begin
            ans_d = ERR_CODE;
        end else begin
            ans_d = result[31:0];
        end
    end

    always_ff @(posedge sw_clk) begin
        if (rst) begin
            ans_q <= 32'd0;
        end else begin
            ans_q <= ans_d;
        end
    end

    assign ans = ans_q;

endmodule

// File: tb/tb_calculate_unit.sv
// Directed bench for calculate_unit with hand-computed expected results.
module tb_calculate_unit;

    localparam logic [31:0] ERR = 32'h00EE_0000;

    logic        sw_clk;
    logic        rst;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [2:0]  operator;
    logic [31:0] ans;

    int checks;
    int failures;

    calculate_unit dut (
        .sw_clk   (sw_clk),
        .rst      (rst),
        .operand1 (operand1),
        .operand2 (operand2),
        .operator (operator),
        .ans      (ans)
    );

    // Clock and reset
    initial sw_clk = 1'b0;
    always #5 sw_clk = ~sw_clk;

    task automatic check_eq(input string tag, input logic [31:0] actual,
                            input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
                     tag, $signed(actual), actual, $signed(expected), expected);
        end
    endtask

    // Drive inputs on the falling edge, let one rising edge capture them,
    // then sample just after that edge.
    task automatic run_vec(input string tag, input int a, input int b,
                           input logic [2:0] op, input logic [31:0] expected);
        @(negedge sw_clk);
        operand1 = a;
        operand2 = b;
        operator = op;
        @(posedge sw_clk);
        #1;
        check_eq(tag, ans, expected);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        operand1 = 32'd10;
        operand2 = 32'd101;
        operator = 3'd3;

        // Reset held for two edges with a valid operation present.
        repeat (2) @(posedge sw_clk);
        #1;
        check_eq("reset", ans, 32'd0);
        @(negedge sw_clk);
        rst = 1'b0;
        @(posedge sw_clk);
        #1;
        check_eq("post_reset_10+101", ans, 32'd111);

        run_vec("10+101", 10, 101, 3'd3, 32'd111);
        run_vec("10-101", 10, 101, 3'd4, -32'sd91);
        run_vec("10*101", 10, 101, 3'd1, 32'd1010);
        run_vec("10/101", 10, 101, 3'd2, 32'd0);
        run_vec("10%101", 10, 101, 3'd5, 32'd10);

        run_vec("-10+101", -10, 101, 3'd3, 32'd91);
        run_vec("-10-101", -10, 101, 3'd4, -32'sd111);
        run_vec("-10*101", -10, 101, 3'd1, -32'sd1010);
        run_vec("-10/101", -10, 101, 3'd2, 32'd0);
        run_vec("-10%101", -10, 101, 3'd5, -32'sd10);

        run_vec("-10+-101", -10, -101, 3'd3, -32'sd111);
        run_vec("-10--101", -10, -101, 3'd4, 32'd91);
        run_vec("-10*-101", -10, -101, 3'd1, 32'd1010);
        run_vec("-10/-101", -10, -101, 3'd2, 32'd0);
        run_vec("-10%-101", -10, -101, 3'd5, -32'sd10);

        run_vec("1e5+-500", 100000, -500, 3'd3, 32'd99500);
        run_vec("1e5--500", 100000, -500, 3'd4, 32'd100500);
        run_vec("1e5*-500", 100000, -500, 3'd1, ERR);
        run_vec("1e5/-500", 100000, -500, 3'd2, -32'sd200);
        run_vec("1e5%-500", 100000, -500, 3'd5, 32'd0);

        run_vec("1023+0", 1023, 0, 3'd3, 32'd1023);
        run_vec("1023-0", 1023, 0, 3'd4, 32'd1023);
        run_vec("1023*0", 1023, 0, 3'd1, 32'd0);
        run_vec("1023/0", 1023, 0, 3'd2, ERR);
        run_vec("1023%0", 1023, 0, 3'd5, ERR);
        run_vec("op6", 1023, 5, 3'd6, ERR);
        run_vec("op7", 1023, 5, 3'd7, ERR);

        run_vec("op0_pass", 42, 7, 3'd0, 32'd42);
        run_vec("op0_neg", -99999, 7, 3'd0, -32'sd99999);
        run_vec("op0_range", 1000000, 7, 3'd0, ERR);
        run_vec("op2_range", 5, -100000, 3'd3, ERR);

        run_vec("999998+1", 999998, 1, 3'd3, 32'd999999);
        run_vec("999999+1", 999999, 1, 3'd3, ERR);
        run_vec("-99998-1", -99998, 1, 3'd4, -32'sd99999);
        run_vec("-99999-1", -99999, 1, 3'd4, ERR);
        run_vec("err_chain", 32'h00EE_0000, 1, 3'd3, ERR);
        run_vec("neg_zero", -7, 7, 3'd3, 32'd0);

        // Steady inputs keep ans steady.
        run_vec("hold_a", 123, 4, 3'd1, 32'd492);
        @(posedge sw_clk);
        #1;
        check_eq("hold_b", ans, 32'd492);

        // Reset asserted mid-sequence clears ans at the next edge.
        @(negedge sw_clk);
        rst = 1'b1;
        @(posedge sw_clk);
        #1;
        check_eq("mid_reset", ans, 32'd0);
        @(negedge sw_clk);
        rst = 1'b0;
        @(posedge sw_clk);
        #1;
        check_eq("after_mid_reset", ans, 32'd492);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
